// File: rtl/switch_box_cfg_loader.sv
// rtl/switch_box_cfg_loader.sv - atomic configuration loader for a row of switch box elements
//
// Purpose:
//   Collects one CFG_W-bit select word per switch box element from a
//   valid/ready stream into a shadow bank. Once every element has a word,
//   the whole bank is copied to the live cfg_out on a single edge. Each
//   element's byte is its c select bus:
//   c[1:0] north_out, c[3:2] east_out, c[5:4] south_out, c[7:6] west_out.
//
// Ports:
//   clk        in   1               clock, all state changes on posedge
//   rst        in   1               asynchronous active-high reset
//   start      in   1               begin or restart a load sequence
//   cfg_valid  in   1               cfg_data holds a word
//   cfg_ready  out  1               a word is accepted this cycle
//   cfg_data   in   CFG_W           config word for the next element
//   cfg_out    out  NUM_ELEM*CFG_W  live config, element k at [k*CFG_W +: CFG_W]
//   busy       out  1               a load or commit is in progress
//   done       out  1               one-cycle pulse, new cfg_out is visible
//   err        out  1               sticky protocol error (word offered while not loading)

module switch_box_cfg_loader #(
  parameter int NUM_ELEM = 4,
  parameter int CFG_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [CFG_W-1:0]          cfg_data,
  output logic [NUM_ELEM*CFG_W-1:0] cfg_out,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int CNT_W = $clog2(NUM_ELEM);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ELEM - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [CNT_W-1:0]          cnt;
  logic [NUM_ELEM*CFG_W-1:0] shadow;
  logic                      xfer;
  logic                      last;

  // start takes priority over a word offered in the same cycle, so the
  // word is held off rather than written into the sequence being discarded.
  assign cfg_ready = (state == LOAD) && !start;
  assign xfer      = cfg_valid && cfg_ready;
  assign last      = (cnt == LAST_IDX);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (!start && xfer && last) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      shadow  <= '0;
      cfg_out <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= (state == COMMIT);
      case (state)
        IDLE: begin
          // An accepted start clears err even if a stray word arrives with it.
          if (start) begin
            cnt <= '0;
            err <= 1'b0;
          end else if (cfg_valid) begin
            err <= 1'b1;
          end
        end
        LOAD: begin
          if (start) begin
            cnt <= '0;
          end else if (xfer) begin
            for (int k = 0; k < NUM_ELEM; k++) begin
              if (cnt == CNT_W'(k)) begin
                shadow[k*CFG_W +: CFG_W] <= cfg_data;
              end
            end
            // Saturate on the final element; COMMIT follows immediately.
            if (!last) begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        COMMIT: begin
          cfg_out <= shadow;
          if (cfg_valid) begin
            err <= 1'b1;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_box_cfg_loader.sv
// tb/tb_switch_box_cfg_loader.sv - scoreboard bench for switch_box_cfg_loader

module tb_switch_box_cfg_loader;

  localparam int NUM_ELEM = 4;
  localparam int CFG_W    = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      start;
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [CFG_W-1:0]          cfg_data;
  logic [NUM_ELEM*CFG_W-1:0] cfg_out;
  logic                      busy;
  logic                      done;
  logic                      err;

  switch_box_cfg_loader #(.NUM_ELEM(NUM_ELEM), .CFG_W(CFG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_out   (cfg_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;
  int pushed_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] live_exp = '0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  // Monitor: pops an expected configuration whenever done pulses and
  // insists cfg_out holds the last committed value on every other cycle.
  always @(negedge clk) begin
    if (rst) begin
      live_exp = '0;
      prev_done = 1'b0;
    end else begin
      if (done === 1'b1) begin
        done_cnt++;
        check("done_single_cycle", {63'd0, prev_done}, 64'd0);
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_commit: actual cfg_out %h required no commit", cfg_out);
        end else begin
          live_exp = exp_q.pop_front();
        end
      end
      check("cfg_out_live", {32'd0, cfg_out}, {32'd0, live_exp});
      prev_done = done;
    end
  end

  // Switch box element: output d takes input (d + 1 + sel) mod 4,
  // directions ordered north, east, south, west; 4-bit lanes.
  function automatic logic [15:0] elem(input logic [7:0] c, input logic [15:0] in_lanes);
    logic [15:0] o;
    int src;
    o = '0;
    for (int d = 0; d < 4; d++) begin
      src = (d + 1 + int'(c[2*d +: 2])) % 4;
      o[4*d +: 4] = in_lanes[4*src +: 4];
    end
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input int gap);
    bit ok;
    repeat (gap) tick();
    cfg_valid = 1'b1;
    cfg_data  = w;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cfg_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    cfg_valid = 1'b0;
    if (!ok) begin
      total_cnt++;
      $display("FAIL word_accept: actual not accepted required accepted (word %h)", w);
    end
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        idle = 1'b1;
        break;
      end
    end
    tick();
    if (!idle) begin
      total_cnt++;
      $display("FAIL idle_timeout: actual busy required idle");
    end
  endtask

  // Issues a sequence of n words after a start; only a complete set of
  // NUM_ELEM words produces an expected commit.
  task automatic load_seq(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                          input logic [7:0] w3, input int n, input int max_gap);
    logic [7:0] w[4];
    logic [31:0] e;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    if (n == NUM_ELEM) begin
      e = '0;
      for (int k = 0; k < NUM_ELEM; k++) e[8*k +: 8] = w[k];
      exp_q.push_back(e);
      pushed_cnt++;
    end
    do_start();
    for (int k = 0; k < n; k++) send_word(w[k], $urandom_range(0, max_gap));
  endtask

  initial begin
    logic [15:0] lanes;
    logic [15:0] want;
    int base;
    int n;
    rst = 1'b1;
    start = 1'b0;
    cfg_valid = 1'b0;
    cfg_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // 1: reset state
    check("reset_cfg_out", {32'd0, cfg_out}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_ready", {63'd0, cfg_ready}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_err", {63'd0, err}, 64'd0);

    // 2: back-to-back load with latency checks
    load_seq(8'h24, 8'h39, 8'h1B, 8'hE4, 4, 0);
    @(negedge clk);
    check("commit_state_busy", {63'd0, busy}, 64'd1);
    check("commit_state_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    check("done_after_commit", {63'd0, done}, 64'd1);
    check("cfg_out_t2", {32'd0, cfg_out}, {32'd0, 32'hE41B3924});
    tick();
    @(negedge clk);
    check("done_cleared", {63'd0, done}, 64'd0);
    check("busy_after", {63'd0, busy}, 64'd0);
    tick();
    for (int i = 0; i < 100; i++) begin
      lanes = 16'($urandom);
      want = {lanes[3:0], lanes[7:4], lanes[15:12], lanes[7:4]};
      check("element0_route", {48'd0, elem(cfg_out[7:0], lanes)}, {48'd0, want});
    end

    // 3: same words with random valid gaps
    load_seq(8'h24, 8'h39, 8'h1B, 8'hE4, 4, 3);
    wait_idle();
    check("cfg_out_t3", {32'd0, cfg_out}, {32'd0, 32'hE41B3924});

    // 4: aborted loads never reach cfg_out
    base = done_cnt;
    load_seq(8'h11, 8'h11, 8'h11, 8'h11, 4, 0);
    wait_idle();
    load_seq(8'hAA, 8'hAA, 8'h00, 8'h00, 2, 1);
    check("abort_hold", {32'd0, cfg_out}, {32'd0, 32'h11111111});
    load_seq(8'h55, 8'h55, 8'h55, 8'h55, 4, 0);
    wait_idle();
    check("cfg_out_t4", {32'd0, cfg_out}, {32'd0, 32'h55555555});
    check("done_pulses_t4", 64'(done_cnt - base), 64'd2);

    // random loads with random aborts
    for (int it = 0; it < 12; it++) begin
      n = $urandom_range(1, 4);
      load_seq(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), n, 2);
      if (n == 4) wait_idle();
    end
    load_seq(8'h55, 8'h55, 8'h55, 8'h55, 4, 0);
    wait_idle();
    check("err_clean", {63'd0, err}, 64'd0);

    // 5: word offered while idle
    cfg_valid = 1'b1;
    cfg_data = 8'hFF;
    @(negedge clk);
    check("idle_ready", {63'd0, cfg_ready}, 64'd0);
    tick();
    cfg_valid = 1'b0;
    @(negedge clk);
    check("idle_err", {63'd0, err}, 64'd1);
    check("idle_cfg_out", {32'd0, cfg_out}, {32'd0, 32'h55555555});
    tick();
    do_start();
    check("start_clears_err", {63'd0, err}, 64'd0);
    check("start_busy", {63'd0, busy}, 64'd1);

    // 6: async reset in the middle of a load
    for (int k = 0; k < 3; k++) send_word(8'h77, 0);
    #2 rst = 1'b1;
    #1;
    check("async_cfg_out", {32'd0, cfg_out}, 64'd0);
    check("async_busy", {63'd0, busy}, 64'd0);
    check("async_ready", {63'd0, cfg_ready}, 64'd0);
    tick();
    rst = 1'b0;
    cfg_valid = 1'b1;
    cfg_data = 8'h77;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_accept_after_rst", {63'd0, cfg_ready}, 64'd0);
    end
    tick();
    cfg_valid = 1'b0;
    check("post_rst_cfg_out", {32'd0, cfg_out}, 64'd0);
    check("post_rst_err", {63'd0, err}, 64'd1);

    load_seq(8'h0F, 8'hF0, 8'h33, 8'hCC, 4, 1);
    wait_idle();
    check("recover_cfg_out", {32'd0, cfg_out}, {32'd0, 32'hCC33F00F});
    repeat (2) tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("done_total", 64'(done_cnt), 64'(pushed_cnt));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
